// File: rtl/prefix_adder_bist.sv
// Exhaustive self-test sweep for a WIDTH-bit adder: walks every (A,B) pair,
// compares the adder output with a full-width reference and logs the first failure.
module prefix_adder_bist #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   input  logic [WIDTH:0]     dut_sum,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b,
   output logic [WIDTH:0]     fail_sum,
   output logic [1:0]         dbg_state_o
);

   localparam int EW = 2 * WIDTH + 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [EW-1:0]    err_q, err_d;
   logic [WIDTH-1:0] fa_q, fa_d;
   logic [WIDTH-1:0] fb_q, fb_d;
   logic [WIDTH:0]   fs_q, fs_d;

   logic [WIDTH:0]   ref_sum;
   logic             mismatch;
   logic             last_vec;

   // Reference is computed one bit wider so the carry-out is compared too.
   assign ref_sum  = {1'b0, a_q} + {1'b0, b_q};
   assign mismatch = (dut_sum != ref_sum);
   assign last_vec = (&a_q) && (&b_q);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      fs_d    = fs_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d    = '0;
               b_d    = '0;
               cnt_d  = '0;
               err_d  = '0;
               fa_d   = '0;
               fb_d   = '0;
               fs_d   = '0;
               done_d = 1'b0;
               busy_d = 1'b1;
               if (LATENCY == 0) state_d = S_CHECK;
               else              state_d = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_CHECK: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end else begin
               if (mismatch) begin
                  err_d = err_q + EW'(1);
                  if (err_q == '0) begin
                     fa_d = a_q;
                     fb_d = b_q;
                     fs_d = dut_sum;
                  end
               end
               // B is the inner loop; A advances only when B wraps.
               b_d = b_q + WIDTH'(1);
               if (&b_q) a_d = a_q + WIDTH'(1);
               if (last_vec) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else if (LATENCY == 0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_SETTLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      pass_d = done_d && (err_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fa_q    <= '0;
         fb_q    <= '0;
         fs_q    <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         fs_q    <= fs_d;
      end
   end

   assign op_a        = a_q;
   assign op_b        = b_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_count   = err_q;
   assign fail_a      = fa_q;
   assign fail_b      = fb_q;
   assign fail_sum    = fs_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prefix_adder_bist.sv
// Bench for prefix_adder_bist: a reduced-width instance with a registered adder
// model (LATENCY=1) and a tiny combinational one (LATENCY=0).
module tb_prefix_adder_bist;

   localparam int W     = 4;
   localparam int L     = 1;
   localparam int N     = 1 << W;
   localparam int SWEEP = N * N * (L + 1);
   localparam int W0    = 3;
   localparam int N0    = 1 << W0;
   localparam int SWEEP0 = N0 * N0;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [W-1:0] op_a, op_b, fail_a, fail_b;
   logic [W:0]   sum1, fail_sum;
   logic         busy, done, pass;
   logic [2*W:0] err_count;
   logic [1:0]   dbg_state;

   logic start0 = 1'b0;
   logic [W0-1:0] op_a0, op_b0, fail_a0, fail_b0;
   logic [W0:0]   sum0, fail_sum0;
   logic          busy0, done0, pass0;
   logic [2*W0:0] err_count0;
   logic [1:0]    dbg_state0;

   int checks = 0;
   int failures = 0;

   // Adder fault modes: 0 good, 1 carry stuck 0, 2 A+B+1, 3 single bad pair, 4 stuck sum bit
   int           mode = 0;
   logic [W-1:0] fault_a, fault_b;
   logic [W:0]   fault_mask;
   int           stuck_bit;
   logic         stuck_val;
   logic         mode0_plus1 = 1'b0;

   always #5 clk = ~clk;

   prefix_adder_bist #(.WIDTH(W), .LATENCY(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .op_a(op_a), .op_b(op_b), .dut_sum(sum1),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum),
      .dbg_state_o(dbg_state)
   );

   prefix_adder_bist #(.WIDTH(W0), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
      .op_a(op_a0), .op_b(op_b0), .dut_sum(sum0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
      .fail_a(fail_a0), .fail_b(fail_b0), .fail_sum(fail_sum0),
      .dbg_state_o(dbg_state0)
   );

   function automatic logic [W:0] adder_resp(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (m)
         1: s[W] = 1'b0;
         2: s = s + (W+1)'(1);
         3: if (a == fault_a && b == fault_b) s = s ^ fault_mask;
         4: s[stuck_bit] = stuck_val;
         default: ;
      endcase
      return s;
   endfunction

   // One-cycle-latency adder under test.
   always @(posedge clk) sum1 <= adder_resp(op_a, op_b, mode);
   assign sum0 = {1'b0, op_a0} + {1'b0, op_b0} + (mode0_plus1 ? (W0+1)'(1) : (W0+1)'(0));

   // Walks all pairs in sweep order and predicts the final error log.
   task automatic model_sweep(input int m, output logic [2*W:0] e, output logic [W-1:0] fa,
                              output logic [W-1:0] fb, output logic [W:0] fs);
      logic [W:0] r;
      e = '0; fa = '0; fb = '0; fs = '0;
      for (int a = 0; a < N; a++) begin
         for (int b = 0; b < N; b++) begin
            r = adder_resp(W'(a), W'(b), m);
            if (r != (W+1)'(a + b)) begin
               if (e == '0) begin
                  fa = W'(a); fb = W'(b); fs = r;
               end
               e = e + 1'b1;
            end
         end
      end
   endtask

   task automatic run_sweep(input int extra_at, output int busy_cycles, output bit pass_early,
                            output bit timed_out);
      busy_cycles = 0; pass_early = 1'b0; timed_out = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 4 * SWEEP; i++) begin
         if (done) begin
            timed_out = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
         if (pass) pass_early = 1'b1;
         start = (extra_at >= 0 && busy_cycles == extra_at);
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL sweep_timeout: done not seen within %0d cycles", 4 * SWEEP);
      end
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({op_a, op_b, busy, done, pass, err_count, fail_a, fail_b, fail_sum, dbg_state} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got a=%0d b=%0d busy=%b done=%b pass=%b err=%0d state=%0d, want all 0",
                  op_a, op_b, busy, done, pass, err_count, dbg_state);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_idle: got busy=%b done=%b state=%0d, want 0 0 0", busy, done, dbg_state);
      end
   endtask

   task automatic test_correct;
      int bc; bit pe, to;
      mode = 0;
      run_sweep(-1, bc, pe, to);
      checks++;
      if (bc !== SWEEP) begin
         failures++; $display("FAIL good_busy_cycles: got %0d want %0d", bc, SWEEP);
      end
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || err_count !== '0) begin
         failures++;
         $display("FAIL good_result: got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
      end
      checks++;
      if (pe) begin
         failures++; $display("FAIL pass_before_done: got pass=1 while done=0, want 0");
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL done_hold: got done=%b busy=%b want 1 0", done, busy);
      end
   endtask

   task automatic test_carry_stuck;
      int bc; bit pe, to;
      mode = 1;
      run_sweep(-1, bc, pe, to);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || err_count !== (2*W+1)'(120)) begin
         failures++;
         $display("FAIL carry_stuck_count: got done=%b pass=%b err=%0d want 1 0 120", done, pass, err_count);
      end
      checks++;
      if (fail_a !== W'(1) || fail_b !== W'(15) || fail_sum !== '0) begin
         failures++;
         $display("FAIL carry_stuck_first: got a=%0d b=%0d s=%0d want 1 15 0", fail_a, fail_b, fail_sum);
      end
   endtask

   task automatic test_plus_one;
      int bc; bit pe, to;
      mode = 2;
      run_sweep(-1, bc, pe, to);
      checks++;
      if (err_count !== (2*W+1)'(N * N) || pass !== 1'b0) begin
         failures++; $display("FAIL plus_one_count: got err=%0d pass=%b want %0d 0", err_count, pass, N * N);
      end
      checks++;
      if (fail_a !== '0 || fail_b !== '0 || fail_sum !== (W+1)'(1)) begin
         failures++;
         $display("FAIL plus_one_first: got a=%0d b=%0d s=%0d want 0 0 1", fail_a, fail_b, fail_sum);
      end
   endtask

   task automatic test_random_faults;
      int bc; bit pe, to;
      logic [2*W:0] e; logic [W-1:0] fa, fb; logic [W:0] fs;
      for (int it = 0; it < 4; it++) begin
         mode       = (it % 2 == 0) ? 3 : 4;
         fault_a    = W'($urandom_range(0, N - 1));
         fault_b    = W'($urandom_range(0, N - 1));
         fault_mask = (W+1)'($urandom_range(1, 2 * N - 1));
         stuck_bit  = $urandom_range(0, W);
         stuck_val  = 1'($urandom_range(0, 1));
         model_sweep(mode, e, fa, fb, fs);
         run_sweep(-1, bc, pe, to);
         checks++;
         if (err_count !== e || pass !== (e == '0)) begin
            failures++;
            $display("FAIL rand_count[%0d]: got err=%0d pass=%b want %0d %b", it, err_count, pass, e, e == '0);
         end
         checks++;
         if (fail_a !== fa || fail_b !== fb || fail_sum !== fs) begin
            failures++;
            $display("FAIL rand_first[%0d]: got a=%0d b=%0d s=%0d want %0d %0d %0d",
                     it, fail_a, fail_b, fail_sum, fa, fb, fs);
         end
      end
   endtask

   task automatic test_back_to_back_start;
      int bc; bit pe, to;
      mode = 2;
      run_sweep($urandom_range(50, SWEEP - 50), bc, pe, to);
      checks++;
      if (bc !== SWEEP || err_count !== (2*W+1)'(N * N)) begin
         failures++;
         $display("FAIL restart_ignored: got busy_cycles=%0d err=%0d want %0d %0d", bc, err_count, SWEEP, N * N);
      end
   endtask

   task automatic test_abort;
      int k, bc; bit pe, to;
      logic [2*W:0] exp_err;
      mode = 2;
      k = $urandom_range(20, SWEEP - 20);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (k - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      // Every vector fails in this mode; one vector completes every L+1 cycles.
      exp_err = (2*W+1)'((k - 1) / (L + 1));
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0 || err_count !== exp_err) begin
         failures++;
         $display("FAIL abort_state: got busy=%b done=%b state=%0d err=%0d want 0 0 0 %0d",
                  busy, done, dbg_state, err_count, exp_err);
      end
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL start_wins_idle: got busy=%b want 1", busy);
      end
      repeat ($urandom_range(3, 40)) @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL abort_wins_busy: got busy=%b done=%b want 0 0", busy, done);
      end
      run_sweep(-1, bc, pe, to);
      checks++;
      if (bc !== SWEEP || err_count !== (2*W+1)'(N * N)) begin
         failures++;
         $display("FAIL after_abort_sweep: got busy_cycles=%0d err=%0d want %0d %0d", bc, err_count, SWEEP, N * N);
      end
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++;
      if (done !== 1'b1 || err_count !== (2*W+1)'(N * N)) begin
         failures++; $display("FAIL abort_when_done: got done=%b err=%0d want 1 %0d", done, err_count, N * N);
      end
   endtask

   task automatic test_reset_mid_sweep;
      int bc; bit pe, to;
      mode = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat ($urandom_range(30, SWEEP - 30)) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({op_a, op_b, busy, done, pass, err_count, fail_a, fail_b, fail_sum, dbg_state} !== '0) begin
         failures++;
         $display("FAIL midsweep_reset_async: got a=%0d b=%0d busy=%b err=%0d fa=%0d fs=%0d, want all 0",
                  op_a, op_b, busy, err_count, fail_a, fail_sum);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || op_a !== '0 || op_b !== '0 || err_count !== '0) begin
         failures++;
         $display("FAIL no_progress_after_reset: got busy=%b done=%b a=%0d b=%0d err=%0d want all 0",
                  busy, done, op_a, op_b, err_count);
      end
      mode = 0;
      run_sweep(-1, bc, pe, to);
      checks++;
      if (bc !== SWEEP || pass !== 1'b1) begin
         failures++; $display("FAIL sweep_after_reset: got busy_cycles=%0d pass=%b want %0d 1", bc, pass, SWEEP);
      end
   endtask

   task automatic test_latency0;
      int bc;
      for (int pass_no = 0; pass_no < 2; pass_no++) begin
         mode0_plus1 = (pass_no == 1);
         bc = 0;
         @(negedge clk); start0 = 1'b1;
         @(negedge clk); start0 = 1'b0;
         for (int i = 0; i < 4 * SWEEP0 && !done0; i++) begin
            if (busy0) bc++;
            @(negedge clk);
         end
         checks++;
         if (done0 !== 1'b1 || bc !== SWEEP0) begin
            failures++; $display("FAIL lat0_timing[%0d]: got done=%b busy_cycles=%0d want 1 %0d",
                                 pass_no, done0, bc, SWEEP0);
         end
         checks++;
         if (err_count0 !== (2*W0+1)'(pass_no == 1 ? SWEEP0 : 0) || pass0 !== (pass_no == 0)) begin
            failures++; $display("FAIL lat0_result[%0d]: got err=%0d pass=%b want %0d %b",
                                 pass_no, err_count0, pass0, pass_no == 1 ? SWEEP0 : 0, pass_no == 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_correct();
      test_carry_stuck();
      test_plus_one();
      test_random_faults();
      test_back_to_back_start();
      test_abort();
      test_reset_mid_sweep();
      test_latency0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prefix_adder_bist.md
PREFIX_ADDER_BIST -- requirements
Module: prefix_adder_bist

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width of the adder under test.
REQ-002 The block SHALL have parameter LATENCY, default 1, giving the clock cycles from operand change to a valid dut_sum; legal range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a sweep.
REQ-006 The block SHALL have port abort, input, 1 bit: a one-cycle pulse that cancels a running sweep.
REQ-007 The block SHALL have port op_a, output, WIDTH bits: operand A driven to the adder.
REQ-008 The block SHALL have port op_b, output, WIDTH bits: operand B driven to the adder.
REQ-009 The block SHALL have port dut_sum, input, WIDTH+1 bits: the adder result, with the carry-out in the MSB.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a sweep runs.
REQ-011 The block SHALL have port done, output, 1 bit: high once a sweep completes, held until the next start or reset.
REQ-012 The block SHALL have port pass, output, 1 bit: equals done AND (err_count == 0).
REQ-013 The block SHALL have port err_count, output, 2*WIDTH+1 bits: the number of mismatching vectors.
REQ-014 The block SHALL have ports fail_a, fail_b (WIDTH bits each) and fail_sum (WIDTH+1 bits), all outputs: the operands and DUT result of the first mismatch.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE, and SHALL reset to IDLE.
REQ-016 In IDLE or DONE, start SHALL do all of the following: clear op_a, op_b, err_count and the fail_* registers; clear done; set busy; enter SETTLE.
REQ-017 SETTLE SHALL hold the operands for LATENCY cycles and then enter CHECK; with LATENCY=0 it SHALL take zero cycles, so the sweep goes straight to CHECK.
REQ-018 In CHECK, the block SHALL compare dut_sum against the full-width reference op_a+op_b, computed in WIDTH+1 bits with no truncation.
REQ-019 On a mismatch, err_count SHALL increment by 1.
REQ-020 If err_count was 0 before a mismatch, the block SHALL capture op_a, op_b and dut_sum into fail_a, fail_b and fail_sum; later mismatches SHALL NOT overwrite them.
REQ-021 After CHECK, the block SHALL step op_b by 1.
REQ-022 When op_b wraps from all-ones to 0, the block SHALL also step op_a by 1.
REQ-023 Vector order SHALL be B-inner, A-outer, starting at (0,0).
REQ-024 A CHECK of vector (all-ones, all-ones) SHALL end the sweep: op_a and op_b wrap to 0, busy falls, done rises the next cycle, and the FSM enters DONE.
REQ-025 Each vector SHALL take exactly LATENCY+1 cycles, so one sweep takes 2^(2*WIDTH)*(LATENCY+1) cycles from start to done.
REQ-026 err_count SHALL NOT saturate; its width holds the maximum of 2^(2*WIDTH) errors exactly.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort while busy SHALL return the FSM to IDLE with busy=0 and done=0, while err_count and fail_* keep their values.
REQ-029 abort outside busy SHALL be ignored.
REQ-030 If start and abort are both asserted in the same cycle, abort SHALL take priority when busy, and start SHALL take priority when not busy.
REQ-031 pass SHALL be 0 whenever done is 0.

Reset
REQ-032 When rst_n is low, the block SHALL immediately set state=IDLE and drive 0 on op_a, op_b, busy, done, pass, err_count, fail_a, fail_b and fail_sum, independent of clk.
REQ-033 A reset during a sweep SHALL discard all progress, and after reset release the block SHALL require a fresh start.
REQ-034 The reset release SHALL be synchronized by the environment; the block SHALL need no internal reset sequencing.

Verification (WIDTH=8, LATENCY=1)
REQ-035 The bench SHALL cover: correct adder model, start pulse -> busy for 131072 cycles, then done=1, pass=1, err_count=0.
REQ-036 The bench SHALL cover: DUT with carry bit S[8] stuck at 0 -> done=1, pass=0, err_count=32640, fail_a=1, fail_b=255, fail_sum=0.
REQ-037 The bench SHALL cover: DUT returning A+B+1 -> err_count=65536 (17'h10000), fail_a=0, fail_b=0, fail_sum=1.
REQ-038 The bench SHALL cover: start at cycle 0, second start at cycle 500 -> no restart; done still appears at cycle 131072 with the correct error count.
REQ-039 The bench SHALL cover: abort at cycle 1000 -> IDLE, busy=0, done=0, err_count unchanged; a following start completes a full sweep.
REQ-040 The bench SHALL cover: rst_n low for 2 cycles mid-sweep -> all outputs 0 asynchronously before the next clk edge; no progress until a new start.
